pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer: BOOT -> FETCH -> EXEC loop with next-PC select; ALIGN_CHECK_EN adds misaligned-target redirect.
// Latency: one cycle per state, so two cycles minimum per instruction (ack in first FETCH, exec_done in first EXEC).
// Backpressure: FETCH holds imem_req until imem_ack; EXEC holds instr_valid until exec_done; stray handshakes are ignored.
module pc_sequencer #(
  parameter logic [31:0] BASE    = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] idx26,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        fetch_fire;
  logic        exec_fire;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic [31:0] pc_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  // Handshakes only count in the state that owns them.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fire  = 1'b0;
    exec_fire   = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_fire = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          exec_fire = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = pc4;
    case (npc_sel)
      2'b00: npc = pc4;
      2'b01: npc = pc4 + br_off;
      2'b10: npc = {pc4[31:28], idx26, 2'b00};
      2'b11: npc = jr_addr;
      default: npc = pc4;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  logic npc_misaligned;
  assign npc_misaligned = (npc[1:0] != 2'b00);
  assign pc_load        = npc_misaligned ? EXC_VEC : npc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign <= 1'b0;
    else        misalign <= exec_fire && npc_misaligned;
  end
`else
  // EXC_VEC has no effect in this build.
  logic unused_exc_vec;
  assign unused_exc_vec = ^EXC_VEC;
  assign pc_load        = npc;
  assign misalign       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= BASE;
      instr   <= '0;
      retired <= '0;
    end else begin
      if (fetch_fire) instr <= imem_rdata;
      if (exec_fire) begin
        pc      <= pc_load;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes expected fetch/retire records, monitor pops them on observed handshakes.
module tb_pc_sequencer;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] EXC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  npc_sel = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] idx26 = '0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        misalign;

  pc_sequencer #(.BASE(BASE), .EXC_VEC(EXC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .npc_sel(npc_sel), .imm16(imm16), .idx26(idx26), .jr_addr(jr_addr),
    .pc(pc), .retired(retired), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } fetch_t;
  typedef struct { logic [31:0] pc; logic [31:0] ret; logic mis; } exec_t;

  fetch_t fq[$];
  exec_t  eq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc  = BASE;
  logic [31:0] m_ret = '0;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] sel,
                                          input logic [15:0] imm, input logic [25:0] idx,
                                          input logic [31:0] jr);
    logic [31:0] nxt4;
    int off;
    nxt4 = cur + 32'd4;
    off  = int'($signed(imm));
    case (sel)
      2'd0:    return nxt4;
      2'd1:    return nxt4 + 32'(off * 4);
      2'd2:    return (nxt4 & 32'hF000_0000) | (32'(idx) << 2);
      default: return jr;
    endcase
  endfunction

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      if (imem_req === 1'b1) return;
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_req: imem_req got 0 for 100 cycles, expected 1");
    finish_all();
  endtask

  task automatic wait_iv();
    for (int i = 0; i < 100; i++) begin
      if (instr_valid === 1'b1) return;
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_iv: instr_valid got 0 for 100 cycles, expected 1");
    finish_all();
  endtask

  task automatic do_fetch(input int fdly, input logic [31:0] rdata, input bit stray);
    wait_req();
    for (int i = 0; i < fdly; i++) begin
      chk("req_held", 32'(imem_req), 32'd1);
      exec_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      npc_sel   = 2'($urandom);
      imm16     = 16'($urandom);
      jr_addr   = $urandom;
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    exec_done  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    fq.push_back('{addr: m_pc, data: rdata});
    @(negedge clk);
    imem_ack  = 1'b0;
    exec_done = 1'b0;
  endtask

  task automatic do_exec(input int edly, input logic [1:0] sel, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] jr, input bit stray);
    logic [31:0] nxt;
    logic        mis;
    wait_iv();
    for (int i = 0; i < edly; i++) begin
      chk("iv_held", 32'(instr_valid), 32'd1);
      chk("req_low_exec", 32'(imem_req), 32'd0);
      imem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    exec_done  = 1'b1;
    npc_sel    = sel;
    imm16      = imm;
    idx26      = idx;
    jr_addr    = jr;
    imem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_rdata = $urandom;
    nxt = ref_npc(m_pc, sel, imm, idx, jr);
    mis = 1'b0;
    if (ALIGN && nxt[1:0] != 2'b00) begin
      nxt = EXC;
      mis = 1'b1;
    end
    m_pc  = nxt;
    m_ret = m_ret + 32'd1;
    eq.push_back('{pc: m_pc, ret: m_ret, mis: mis});
    @(negedge clk);
    exec_done = 1'b0;
    imem_ack  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_iv"}, 32'(instr_valid), 32'd0);
    chk({tag, "_mis"}, 32'(misalign), 32'd0);
    chk({tag, "_pc"}, pc, BASE);
    chk({tag, "_ret"}, retired, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
  endtask

  task automatic release_and_boot();
    @(negedge clk);
    reset = 1'b1;
    chk("boot_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, BASE);
  endtask

  // Monitor: pops expectations when a fetch or retire handshake is observed.
  initial begin
    logic        p_req, p_iv, e_mis;
    logic [31:0] p_addr, c_pc, c_ret, c_instr;
    fetch_t      f;
    exec_t       e;
    p_req = 1'b0; p_iv = 1'b0; p_addr = '0;
    c_pc = BASE; c_ret = '0; c_instr = '0;
    forever begin
      @(posedge clk);
      #1;
      e_mis = 1'b0;
      if (reset !== 1'b1) begin
        p_req = 1'b0; p_iv = 1'b0;
        c_pc = BASE; c_ret = '0; c_instr = '0;
        continue;
      end
      if (p_req && imem_ack) begin
        if (fq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fetch_unexpected: handshake seen, expected none");
        end else begin
          f = fq.pop_front();
          chk("fetch_addr", p_addr, f.addr);
          c_instr = f.data;
        end
      end
      if (p_iv && exec_done) begin
        if (eq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL exec_unexpected: retire seen, expected none");
        end else begin
          e = eq.pop_front();
          c_pc  = e.pc;
          c_ret = e.ret;
          e_mis = e.mis;
        end
      end
      chk("pc", pc, c_pc);
      chk("retired", retired, c_ret);
      chk("instr", instr, c_instr);
      chk("misalign", 32'(misalign), 32'(e_mis));
      chk("addr_eq_pc", imem_addr, c_pc);
      p_req  = imem_req;
      p_iv   = instr_valid;
      p_addr = imem_addr;
    end
  end

  initial begin
    #500000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_all();
  end

  initial begin
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    release_and_boot();

    do_fetch(0, 32'h2408_0001, 1'b0);
    chk("r035_instr", instr, 32'h2408_0001);
    do_exec(0, 2'b00, '0, '0, '0, 1'b0);
    chk("r035_pc", pc, 32'h3004);
    chk("r035_ret", retired, 32'd1);

    do_fetch(1, $urandom, 1'b0);
    do_exec(0, 2'b01, 16'hFFFF, '0, '0, 1'b0);
    chk("r036_back", pc, 32'h3004);
    do_fetch(0, $urandom, 1'b0);
    do_exec(1, 2'b01, 16'h0003, '0, '0, 1'b0);
    chk("r036_fwd", pc, 32'h3014);

    do_fetch(0, $urandom, 1'b0);
    do_exec(0, 2'b11, '0, '0, 32'h3010, 1'b0);
    do_fetch(0, $urandom, 1'b0);
    do_exec(0, 2'b10, '0, 26'h0000C10, '0, 1'b0);
    chk("r037_jump", pc, 32'h3040);
    do_fetch(0, $urandom, 1'b0);
    do_exec(0, 2'b11, '0, '0, 32'h3000, 1'b0);
    chk("r037_jr", pc, 32'h3000);

    do_fetch(5, 32'hDEAD_BEEF, 1'b1);
    do_exec(3, 2'b00, '0, '0, '0, 1'b1);
    chk("r038_pc", pc, 32'h3004);
    chk("r038_ret", retired, 32'd7);
    chk("r038_instr", instr, 32'hDEAD_BEEF);

    do_fetch(0, $urandom, 1'b0);
    do_exec(0, 2'b11, '0, '0, 32'h3002, 1'b0);
    chk("r040_pc", pc, ALIGN ? 32'h4180 : 32'h3002);
    chk("r040_mis", 32'(misalign), ALIGN ? 32'd1 : 32'd0);
    chk("r040_ret", retired, 32'd8);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] jr;
      jr = $urandom;
      if ($urandom_range(0, 5) != 0) jr[1:0] = 2'b00;
      do_fetch($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
      do_exec($urandom_range(0, 3), 2'($urandom), 16'($urandom), 26'($urandom), jr,
              1'($urandom_range(0, 1)));
    end

    // Reset in EXEC with exec_done high must abandon the instruction.
    do_fetch(0, $urandom, 1'b0);
    do_exec(0, 2'b11, '0, '0, 32'h3008, 1'b0);
    do_fetch(0, $urandom, 1'b0);
    wait_iv();
    exec_done = 1'b1;
    npc_sel   = 2'b00;
    #2 reset = 1'b0;
    #1 check_reset_outputs("r039");
    m_pc  = BASE;
    m_ret = '0;
    @(negedge clk);
    exec_done = 1'b0;
    release_and_boot();
    do_fetch(0, $urandom, 1'b0);
    do_exec(0, 2'b00, '0, '0, '0, 1'b0);
    chk("post_rst_pc", pc, 32'h3004);
    chk("post_rst_ret", retired, 32'd1);

    repeat (3) @(negedge clk);
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("eq_drained", 32'(eq.size()), 32'd0);
    finish_all();
  end
endmodule
